// File: rtl/exp_operand_loader.sv
// Streams a 161-word operand frame into the modular exponentiation core,
// pulses start, then streams the 1024-bit result back out as 32 words.
module exp_operand_loader #(
    parameter int NW = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [NW*32-1:0]     in_x,
    output logic [NW*32-1:0]     in_m,
    output logic [NW*32-1:0]     in_e,
    output logic [NW*32-1:0]     in_r,
    output logic [NW*32-1:0]     in_r2,
    output logic [31:0]          lene,
    output logic                 start,
    input  logic [NW*32-1:0]     result,
    input  logic                 done,
    output logic [31:0]          m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic [2:0]           o_dbg_state
);

    // Handshake: a word moves on s/m only in a cycle where valid && ready;
    // valid never waits on ready, and m_* hold steady while m_ready is low.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_word_cnt;
    logic [2:0]       r_op_idx;
    logic [4:0]       r_out_idx;
    logic             r_armed;
    logic [NW*32-1:0] r_x;
    logic [NW*32-1:0] r_m;
    logic [NW*32-1:0] r_e;
    logic [NW*32-1:0] r_r;
    logic [NW*32-1:0] r_r2;
    logic [NW*32-1:0] r_result;
    logic [31:0]      r_lene;

    logic             w_s_fire;
    logic             w_m_fire;
    logic             w_lene_word;
    logic [9:0]       w_in_base;
    logic [9:0]       w_out_base;

    assign w_s_fire    = s_valid && s_ready;
    assign w_m_fire    = m_valid && m_ready;
    assign w_lene_word = (r_op_idx == 3'd5);
    assign w_in_base   = {r_word_cnt, 5'd0};
    assign w_out_base  = {r_out_idx, 5'd0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_s_fire) w_next = ST_LOAD;
            ST_LOAD:   if (w_s_fire && w_lene_word) w_next = ST_LAUNCH;
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT:   if (done) w_next = ST_SEND;
            ST_SEND:   if (w_m_fire && (r_out_idx == 5'd31)) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // s_ready stays low until the first edge after reset release (r_armed).
    always_comb begin
        s_ready = r_armed && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
        start   = (r_state == ST_LAUNCH);
        m_valid = (r_state == ST_SEND);
        m_last  = (r_state == ST_SEND) && (r_out_idx == 5'd31);
        busy    = (r_state != ST_IDLE);
        m_data  = 32'd0;
        if (r_state == ST_SEND) begin
            m_data = r_result[w_out_base +: 32];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Word counter wraps every operand; the lene word closes the frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_word_cnt <= 5'd0;
            r_op_idx   <= 3'd0;
        end else if (w_s_fire) begin
            if (w_lene_word) begin
                r_word_cnt <= 5'd0;
                r_op_idx   <= 3'd0;
            end else begin
                r_word_cnt <= r_word_cnt + 5'd1;
                if (r_word_cnt == 5'd31) begin
                    r_op_idx <= r_op_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_m    <= '0;
            r_e    <= '0;
            r_r    <= '0;
            r_r2   <= '0;
            r_lene <= 32'd0;
        end else if (w_s_fire) begin
            case (r_op_idx)
                3'd0:    r_x[w_in_base +: 32]  <= s_data;
                3'd1:    r_m[w_in_base +: 32]  <= s_data;
                3'd2:    r_e[w_in_base +: 32]  <= s_data;
                3'd3:    r_r[w_in_base +: 32]  <= s_data;
                3'd4:    r_r2[w_in_base +: 32] <= s_data;
                3'd5:    r_lene                <= s_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_result  <= '0;
            r_out_idx <= 5'd0;
        end else if ((r_state == ST_WAIT) && done) begin
            r_result  <= result;
            r_out_idx <= 5'd0;
        end else if (w_m_fire) begin
            r_out_idx <= r_out_idx + 5'd1;
        end
    end

    assign in_x        = r_x;
    assign in_m        = r_m;
    assign in_e        = r_e;
    assign in_r        = r_r;
    assign in_r2       = r_r2;
    assign lene        = r_lene;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_exp_operand_loader.sv
// Self-checking bench for exp_operand_loader: table of frames, a result
// scoreboard queue, plus hand-written reset-at-word-80 sequence.
module tb_exp_operand_loader;

    localparam int OPW = 1024;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [31:0]    s_data = 32'd0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [OPW-1:0] in_x, in_m, in_e, in_r, in_r2;
    logic [31:0]    lene;
    logic           start;
    logic [OPW-1:0] result = '0;
    logic           done = 1'b0;
    logic [31:0]    m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b0;
    logic           busy;
    logic [2:0]     dbg_state;

    exp_operand_loader #(.NW(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .in_x        (in_x),
        .in_m        (in_m),
        .in_e        (in_e),
        .in_r        (in_r),
        .in_r2       (in_r2),
        .lene        (lene),
        .start       (start),
        .result      (result),
        .done        (done),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_cnt = 0;
    int start_cyc = -1;
    int lene_cyc = -1;
    int starts_before_lene = 0;
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [OPW-1:0] x, m, e, r, r2;
        logic [31:0]    lene;
        int             gap_pct;
        int             stall_mode;
        bit             spurious;
        logic [OPW-1:0] res;
    } vec_t;

    vec_t vecs[4];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_op(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < 32; k++) begin
                if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s word %0d: got %h expected %h", name, k, act[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [OPW-1:0] rand_op();
        logic [OPW-1:0] f;
        for (int k = 0; k < 32; k++) f[k*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [31:0] frame_word(input vec_t v, input int i);
        logic [OPW-1:0] op;
        if (i == 160) return v.lene;
        case (i / 32)
            0:       op = v.x;
            1:       op = v.m;
            2:       op = v.e;
            3:       op = v.r;
            default: op = v.r2;
        endcase
        return op[(i % 32) * 32 +: 32];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check32({tag, "_busy"},    {31'd0, busy},    32'd0);
        check32({tag, "_start"},   {31'd0, start},   32'd0);
        check32({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check32({tag, "_m_last"},  {31'd0, m_last},  32'd0);
        check32({tag, "_m_data"},  m_data,           32'd0);
        check32({tag, "_lene"},    lene,             32'd0);
        check_op({tag, "_in_x"},   in_x,  '0);
        check_op({tag, "_in_r2"},  in_r2, '0);
    endtask

    // Called at posedge+1 with resetn low; leaves the bench at posedge+1.
    task automatic release_reset();
        resetn = 1'b1;
        @(negedge clk);
        check32("s_ready_before_edge", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check32("s_ready_after_edge", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Driver: entered and left at posedge+1.
    task automatic drive_frame(input vec_t v, input int n_words);
        bit acc;
        int n;
        for (int i = 0; i < n_words; i++) begin
            if (v.spurious && i == 50) begin
                s_valid = 1'b0;
                done    = 1'b1;
                result  = {32{32'hDEADBEEF}};
                @(posedge clk); #1;
                done   = 1'b0;
                result = '0;
                @(negedge clk);
                check32("spurious_done_m_valid", {31'd0, m_valid}, 32'd0);
                check32("spurious_done_busy",    {31'd0, busy},    32'd1);
                @(posedge clk); #1;
            end
            while ($urandom_range(99) < v.gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = frame_word(v, i);
            acc = 0;
            n   = 0;
            while (!acc) begin
                @(negedge clk);
                if (s_ready === 1'b1) begin
                    acc = 1;
                    if (i == 160) begin
                        lene_cyc = cyc;
                        starts_before_lene = start_cnt;
                    end
                end
                @(posedge clk); #1;
                n++;
                if (!acc && n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout word %0d: s_ready=%b expected 1", i, s_ready);
                    break;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    // Scoreboard sink: pops exp_q on each m_valid&&m_ready handshake.
    task automatic sink(input int mode);
        int k = 0;
        while (exp_q.size() > 0 && k < 400) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            check32("m_valid_in_send", {31'd0, m_valid}, 32'd1);
            check32("s_ready_in_send", {31'd0, s_ready}, 32'd0);
            if (m_valid === 1'b1) begin
                check32(m_ready ? "m_data" : "m_data_hold", m_data, exp_q[0]);
                check32("m_last", {31'd0, m_last}, {31'd0, exp_q.size() == 1});
                if (m_ready) void'(exp_q.pop_front());
            end
            k++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        check32("result_words_left", exp_q.size(), 32'd0);
        exp_q.delete();
        if (mode == 0) check32("send_cycles_gapless", k, 32'd32);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        start_cnt = 0;
        start_cyc = -1;
        lene_cyc  = -1;
        drive_frame(v, 161);
        repeat (3) @(posedge clk);
        #1;
        check32("start_count", start_cnt, 32'd1);
        check32("start_latency", start_cyc - lene_cyc, 32'd1);
        check32("start_before_lene", starts_before_lene, 32'd0);
        @(negedge clk);
        check_op("in_x", in_x, v.x);
        check_op("in_m", in_m, v.m);
        check_op("in_e", in_e, v.e);
        check_op("in_r", in_r, v.r);
        check_op("in_r2", in_r2, v.r2);
        check32("lene", lene, v.lene);
        check32("busy_in_wait", {31'd0, busy}, 32'd1);
        s_valid = 1'b1;
        s_data  = 32'hBAD0_0000 | idx;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check32("s_ready_in_wait", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        done    = 1'b1;
        result  = v.res;
        for (int k = 0; k < 32; k++) exp_q.push_back(v.res[k*32 +: 32]);
        @(posedge clk); #1;
        done   = 1'b0;
        result = '0;
        sink(v.stall_mode);
        @(negedge clk);
        check32("busy_after_send", {31'd0, busy}, 32'd0);
        check32("m_valid_after_send", {31'd0, m_valid}, 32'd0);
        check32("s_ready_after_send", {31'd0, s_ready}, 32'd1);
        check_op("in_x_held", in_x, v.x);
        check32("lene_held", lene, v.lene);
        check32("start_count_total", start_cnt, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0].x = 1024'd5;  vecs[0].m = 1024'hB; vecs[0].e = 1024'd3;
        vecs[0].r = 1024'd1;  vecs[0].r2 = 1024'd4; vecs[0].lene = 32'd2;
        vecs[0].gap_pct = 0;  vecs[0].stall_mode = 0; vecs[0].spurious = 0;
        vecs[0].res = {16{64'h0123456789ABCDEF}};
        for (int i = 1; i < 4; i++) begin
            vecs[i].x = rand_op(); vecs[i].m = rand_op(); vecs[i].e = rand_op();
            vecs[i].r = rand_op(); vecs[i].r2 = rand_op(); vecs[i].lene = $urandom;
            vecs[i].res = rand_op();
        end
        vecs[1].gap_pct = 30; vecs[1].stall_mode = 1; vecs[1].spurious = 1;
        vecs[2].gap_pct = 0;  vecs[2].stall_mode = 1; vecs[2].spurious = 0;
        vecs[3].gap_pct = 50; vecs[3].stall_mode = 2; vecs[3].spurious = 0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        release_reset();

        for (int i = 0; i < 4; i++) run_vector(vecs[i], i);

        // Reset in the middle of a frame, then a clean full frame.
        start_cnt = 0;
        drive_frame(vecs[3], 80);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        release_reset();
        repeat (5) @(posedge clk);
        #1;
        check32("no_start_after_reset", start_cnt, 32'd0);
        check32("idle_after_reset", {31'd0, busy}, 32'd0);
        run_vector(vecs[0], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
